// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the serial ALU sequencer and its 1-bit slice.
//   Contents:
//     - op_code values seen on the request interface (OP_AND..OP_SLT)
//     - slice operation encodings (SL_AND, SL_OR, SL_ARITH, SL_PASS)
//     - sequencer state encoding (IDLE, RUN, DONE)
//     - is_arith(): true for the ops that use the adder path
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    localparam logic [1:0] SL_AND   = 2'b00;
    localparam logic [1:0] SL_OR    = 2'b01;
    localparam logic [1:0] SL_ARITH = 2'b10;
    localparam logic [1:0] SL_PASS  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ADD, SUB and SLT all run through the full adder and produce flags
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu.sv
// full_adder / alu
//   full_adder: one-bit full adder.
//     a, b, cin -> sum, cout
//   alu: the 1-bit ALU slice built around full_adder.
//     a, b     operand bits
//     i3       pass-through input, selected by SL_PASS
//     cin      carry in
//     add_sub  1 inverts b into the adder (subtract)
//     op       SL_AND / SL_OR / SL_ARITH / SL_PASS
//     r        slice result bit
//     co       adder carry out (always computed, whatever op is)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain sum/majority equations
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

module alu
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       i3,
    input  logic       cin,
    input  logic       add_sub,
    input  logic [1:0] op,
    output logic       r,
    output logic       co
);

    logic b_eff;
    logic sum;

    // Subtract is a + ~b + 1; the +1 arrives on cin of the first bit
    assign b_eff = b ^ add_sub;

    full_adder u_fa (
        .a    (a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (co)
    );

    // Pick the slice output for the requested operation
    always_comb begin
        r = 1'b0;
        case (op)
            SL_AND:   r = a & b;
            SL_OR:    r = a | b;
            SL_ARITH: r = sum;
            default:  r = i3;
        endcase
    end

endmodule

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer
//   Runs the 1-bit slice `alu` over WIDTH-bit operands, one bit per clock,
//   LSB first, and returns the assembled result.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid / in_ready   request handshake (in_ready only while idle)
//     op_code, a_in, b_in   operation and operands (signed for SLT)
//     out_valid / out_ready result handshake (out_valid held until accepted)
//     result                WIDTH-bit result, held until the next completion
//     carry_o, ovf_o, zero_o  flags, present only with SERIAL_ALU_FLAGS_EN
//   Optional feature macro: SERIAL_ALU_FLAGS_EN
module serial_alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, next_state;
    logic [CNT_W-1:0]   count;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [WIDTH-2:0]   r_sh;
    logic               carry_reg;

    logic [1:0]         slice_op;
    logic               add_sub;
    logic               slice_cin;
    logic               slice_r;
    logic               slice_co;
    logic               last_bit;
    logic               ovf_now;
    logic [WIDTH-1:0]   r_next;
    logic [WIDTH-1:0]   final_result;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; in IDLE in_ready is high so in_valid alone is the handshake
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last_bit)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs depend on state only
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Slice control; reserved opcodes run as AND and are zeroed at the end
    always_comb begin
        slice_op = SL_AND;
        if (op_reg == OP_OR)         slice_op = SL_OR;
        else if (is_arith(op_reg))   slice_op = SL_ARITH;
        add_sub   = (op_reg == OP_SUB) || (op_reg == OP_SLT);
        slice_cin = (count == '0) ? add_sub : carry_reg;
        last_bit  = (count == LAST);
    end

    alu u_alu (
        .a       (a_sh[0]),
        .b       (b_sh[0]),
        .i3      (1'b0),
        .cin     (slice_cin),
        .add_sub (add_sub),
        .op      (slice_op),
        .r       (slice_r),
        .co      (slice_co)
    );

    // On the last bit, r_next is the full LSB-aligned result and the
    // carry into the MSB is the current cin, so overflow is cin ^ co.
    // SLT uses sign ^ overflow, which stays right for the most-negative value.
    always_comb begin
        r_next       = {slice_r, r_sh};
        ovf_now      = slice_cin ^ slice_co;
        final_result = '0;
        case (op_reg)
            OP_AND, OP_OR, OP_ADD, OP_SUB: final_result = r_next;
            OP_SLT:  final_result[0] = slice_r ^ ovf_now;
            default: final_result = '0;
        endcase
    end

    // Datapath: operand/result shift registers, bit counter, carry loop
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            op_reg    <= OP_AND;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_reg <= op_code;
                        a_sh   <= a_in;
                        b_sh   <= b_in;
                        count  <= '0;
                    end
                end
                RUN: begin
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    r_sh      <= r_next[WIDTH-1:1];
                    carry_reg <= slice_co;
                    count     <= last_bit ? '0 : count + 1'b1;
                    if (last_bit) result <= final_result;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    // Flags are captured together with the result; AND/OR report no carry or
    // overflow, reserved opcodes report nothing at all
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_o <= 1'b0;
            ovf_o   <= 1'b0;
            zero_o  <= 1'b0;
        end else if (state == RUN && last_bit) begin
            carry_o <= is_arith(op_reg) ? slice_co : 1'b0;
            ovf_o   <= is_arith(op_reg) ? ovf_now  : 1'b0;
            zero_o  <= (op_reg <= OP_SLT) ? (final_result == '0) : 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer
//   Self-checking bench for serial_alu_sequencer (WIDTH=8). Expected
//   results come from a behavioural model and are queued when a request
//   is driven, then popped when the sequencer presents its result.
//   Flag checks are compiled in only with SERIAL_ALU_FLAGS_EN.
module tb_serial_alu_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             carry_o;
    logic             ovf_o;
    logic             zero_o;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             zero;
    } exp_t;

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef SERIAL_ALU_FLAGS_EN
        ,
        .carry_o   (carry_o),
        .ovf_o     (ovf_o),
        .zero_o    (zero_o)
`endif
    );

    // One comparison: count it, report it if it differs
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the whole word
    function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t           e;
        logic [WIDTH:0] t;
        e = '0;
        case (op)
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_ADD: begin
                t       = {1'b0, a} + {1'b0, b};
                e.res   = t[WIDTH-1:0];
                e.carry = t[WIDTH];
                e.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SLT: begin
                t       = {1'b0, a} + {1'b0, ~b} + 1;
                e.carry = t[WIDTH];
                e.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
                if (op == OP_SLT) e.res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
                else              e.res = t[WIDTH-1:0];
            end
            default: e = '0;
        endcase
        if (op <= OP_SLT) e.zero = (e.res == '0);
        return e;
    endfunction

    // Present one request from a falling edge and hold it through the accept edge
    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_request", in_ready, 1);
        op_code  = op;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic compareFlags(input string tag, input exp_t e);
`ifdef SERIAL_ALU_FLAGS_EN
        checkOutput({tag, "_carry"}, carry_o, e.carry);
        checkOutput({tag, "_ovf"},   ovf_o,   e.ovf);
        checkOutput({tag, "_zero"},  zero_o,  e.zero);
`else
        if (tag.len() == 0) $display("[TB] %0h", e.res);
`endif
    endtask

    // Wait (bounded) for the result, check latency and contents, then accept it
    task automatic collectResult(input string tag);
        exp_t e;
        int   lat = 1;
        checkOutput({tag, "_busy"}, in_ready, 0);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, WIDTH + 1);
        checkOutput({tag, "_sb_nonempty"}, scoreboard.size() != 0, 1);
        if (scoreboard.size() != 0) begin
            e = scoreboard.pop_front();
            checkOutput({tag, "_result"}, result, e.res);
            compareFlags(tag, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, out_valid, 0);
        checkOutput({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic runOp(input string tag, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        scoreboard.push_back(model(op, a, b));
        applyStimulus(op, a, b);
        collectResult(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t             held;
        int               lat;
        logic [2:0]       rop;
        logic [WIDTH-1:0] ra, rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_code   = '0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready",  in_ready,  1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_result",    result,    0);
`ifdef SERIAL_ALU_FLAGS_EN
        checkOutput("reset_flags", {carry_o, ovf_o, zero_o}, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        runOp("add_7f_01",  OP_ADD, 8'h7F, 8'h01);
        runOp("add_ff_01",  OP_ADD, 8'hFF, 8'h01);
        runOp("sub_05_05",  OP_SUB, 8'h05, 8'h05);
        runOp("sub_00_01",  OP_SUB, 8'h00, 8'h01);
        runOp("slt_80_7f",  OP_SLT, 8'h80, 8'h7F);
        runOp("slt_7f_80",  OP_SLT, 8'h7F, 8'h80);
        runOp("slt_fe_ff",  OP_SLT, 8'hFE, 8'hFF);
        runOp("slt_80_80",  OP_SLT, 8'h80, 8'h80);
        runOp("and_a5_0f",  OP_AND, 8'hA5, 8'h0F);
        runOp("or_a5_0f",   OP_OR,  8'hA5, 8'h0F);
        runOp("rsv_111",    3'b111, 8'hA5, 8'h0F);
        runOp("rsv_101",    3'b101, 8'hFF, 8'hFF);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            runOp($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        // Backpressure: result must hold while the consumer stalls, and a
        // request offered meanwhile must not be taken
        scoreboard.push_back(model(OP_ADD, 8'h12, 8'h34));
        applyStimulus(OP_ADD, 8'h12, 8'h34);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_latency", lat, WIDTH + 1);
        held = scoreboard.pop_front();
        op_code  = OP_OR;
        a_in     = 8'hFF;
        b_in     = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_valid_%0d", i),  out_valid, 1);
            checkOutput($sformatf("bp_ready_%0d", i),  in_ready,  0);
            checkOutput($sformatf("bp_result_%0d", i), result,    held.res);
        end
        compareFlags("bp", held);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_valid_drop", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp_no_queue_%0d", i), in_ready, 1);
            @(negedge clk);
        end

        // Reset while RUN holds count=3 aborts the operation
        applyStimulus(OP_ADD, 8'h03, 8'h04);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_in_ready",  in_ready,  1);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_result",    result,    0);
        lat = 0;
        for (int i = 0; i < WIDTH + 3; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        checkOutput("abort_no_result", lat, 0);
        runOp("add_after_abort", OP_ADD, 8'h03, 8'h04);
        checkOutput("add_after_abort_value", result, 8'h07);

        checkOutput("sb_drained", scoreboard.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
